// File: rtl/renaming_map.sv
// rtl/renaming_map.sv - register renaming map table with lowest-first free list and commit release
// Carries a minimal ariane_pkg so the block elaborates stand-alone.

package ariane_pkg;
   localparam int REG_ADDR_SIZE = 6;

   typedef struct packed {
      logic [31:0]              pc;
      logic [7:0]               op;
      logic [REG_ADDR_SIZE-1:0] rs1;
      logic [REG_ADDR_SIZE-1:0] rs2;
      logic [REG_ADDR_SIZE-1:0] rd;
      logic [31:0]              result;
   } scoreboard_entry_t;

   typedef struct packed {
      logic              valid;
      scoreboard_entry_t sbe;
      logic              is_ctrl_flow;
   } issue_struct_t;
endpackage

module renaming_map #(
   parameter int ARCH_REG_WIDTH = 5,
   parameter int PHYS_REG_WIDTH = 6
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        fetch_entry_ready_i,
   input  ariane_pkg::issue_struct_t   issue_n,
   output ariane_pkg::issue_struct_t   issue_q,
   input  logic [PHYS_REG_WIDTH-1:0]   waddr_i,
   input  logic                        we_gp_i
);
   import ariane_pkg::*;

   localparam int NUM_ARCH = 1 << ARCH_REG_WIDTH;
   localparam int NUM_PHYS = 1 << PHYS_REG_WIDTH;

   logic [PHYS_REG_WIDTH-1:0] r_map  [NUM_ARCH];
   logic [PHYS_REG_WIDTH-1:0] r_prev [NUM_PHYS];
   logic [NUM_PHYS-1:0]       r_free;
   issue_struct_t             r_issue_q;

   logic [ARCH_REG_WIDTH-1:0] w_rd_arch;
   logic [ARCH_REG_WIDTH-1:0] w_rs1_arch;
   logic [ARCH_REG_WIDTH-1:0] w_rs2_arch;
   logic                      w_accept;
   logic                      w_need_alloc;
   logic                      w_free_any;
   logic [PHYS_REG_WIDTH-1:0] w_alloc_idx;
   logic                      w_do_issue;
   logic [PHYS_REG_WIDTH-1:0] w_release;
   logic                      w_commit;
   issue_struct_t             w_issue_d;

   assign w_rd_arch    = issue_n.sbe.rd[ARCH_REG_WIDTH-1:0];
   assign w_rs1_arch   = issue_n.sbe.rs1[ARCH_REG_WIDTH-1:0];
   assign w_rs2_arch   = issue_n.sbe.rs2[ARCH_REG_WIDTH-1:0];
   assign w_accept     = fetch_entry_ready_i && issue_n.valid;
   assign w_need_alloc = (w_rd_arch != '0);
   // An instruction needing a destination is dropped when nothing is free.
   assign w_do_issue   = w_accept && (!w_need_alloc || w_free_any);

   // Downward scan leaves the lowest-numbered free register in w_alloc_idx.
   always_comb begin
      w_free_any  = 1'b0;
      w_alloc_idx = '0;
      for (int i = NUM_PHYS - 1; i >= 0; i--) begin
         if (r_free[i]) begin
            w_free_any  = 1'b1;
            w_alloc_idx = PHYS_REG_WIDTH'(i);
         end
      end
   end

   always_comb begin
      w_issue_d         = issue_n;
      w_issue_d.valid   = w_do_issue;
      w_issue_d.sbe.rd  = '0;
      w_issue_d.sbe.rs1 = '0;
      w_issue_d.sbe.rs2 = '0;
      if (w_do_issue) begin
         w_issue_d.sbe.rs1 = REG_ADDR_SIZE'(r_map[w_rs1_arch]);
         w_issue_d.sbe.rs2 = REG_ADDR_SIZE'(r_map[w_rs2_arch]);
         if (w_need_alloc) begin
            w_issue_d.sbe.rd = REG_ADDR_SIZE'(w_alloc_idx);
         end
      end
   end

   // Committing waddr_i retires the mapping it displaced, not waddr_i itself.
   assign w_release = r_prev[waddr_i];
   assign w_commit  = we_gp_i && (waddr_i != '0) && (w_release != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_ARCH; i++) begin
            r_map[i] <= PHYS_REG_WIDTH'(i);
         end
         for (int i = 0; i < NUM_PHYS; i++) begin
            r_prev[i] <= '0;
         end
         r_free    <= {{(NUM_PHYS - NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
         r_issue_q <= '0;
      end else begin
         r_issue_q <= w_issue_d;
         if (w_do_issue && w_need_alloc) begin
            r_prev[w_alloc_idx] <= r_map[w_rd_arch];
            r_map[w_rd_arch]    <= w_alloc_idx;
            r_free[w_alloc_idx] <= 1'b0;
         end
         if (w_commit) begin
            r_free[w_release] <= 1'b1;
         end
      end
   end

   assign issue_q = r_issue_q;

endmodule

// File: tb/tb_renaming_map.sv
// tb/tb_renaming_map.sv - randomized and directed bench for renaming_map against a set-based model

module tb_renaming_map;
   import ariane_pkg::*;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          fetch_entry_ready_i = 1'b0;
   issue_struct_t issue_n = '0;
   issue_struct_t issue_q;
   logic [5:0]    waddr_i = '0;
   logic          we_gp_i = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   int            m_map  [32];
   int            m_prev [64];
   bit            m_free [int];
   int            inflight [$];
   issue_struct_t exp_q;

   renaming_map #(.ARCH_REG_WIDTH(5), .PHYS_REG_WIDTH(6)) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .fetch_entry_ready_i (fetch_entry_ready_i),
      .issue_n             (issue_n),
      .issue_q             (issue_q),
      .waddr_i             (waddr_i),
      .we_gp_i             (we_gp_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_map[i] = i;
      for (int i = 0; i < 64; i++) m_prev[i] = 0;
      m_free.delete();
      for (int i = 32; i < 64; i++) m_free[i] = 1'b1;
      inflight.delete();
      exp_q = '0;
   endfunction

   task automatic apply_reset();
      fetch_entry_ready_i = 1'b0;
      issue_n = '0;
      we_gp_i = 1'b0;
      waddr_i = '0;
      rst_ni = 1'b0;
      model_reset();
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
   endtask

   // One clock of stimulus; the model predicts issue_q and updates its own tables.
   task automatic drive_cycle(input bit rdy, input bit v, input int rd, input int rs1, input int rs2,
                              input bit we, input int wa);
      issue_struct_t n;
      int p, rel, ard;
      bit ok;
      n.valid            = v;
      n.is_ctrl_flow     = 1'($urandom);
      n.sbe.pc           = $urandom;
      n.sbe.op           = 8'($urandom);
      n.sbe.result       = $urandom;
      n.sbe.rd           = {1'($urandom), rd[4:0]};
      n.sbe.rs1          = {1'($urandom), rs1[4:0]};
      n.sbe.rs2          = {1'($urandom), rs2[4:0]};
      issue_n             = n;
      fetch_entry_ready_i = rdy;
      we_gp_i             = we;
      waddr_i             = wa[5:0];

      ard = rd[4:0];
      p = 0;
      if (m_free.num() > 0) void'(m_free.first(p));
      ok = rdy && v && (ard == 0 || m_free.num() > 0);
      exp_q = n;
      exp_q.valid = ok;
      exp_q.sbe.rd = '0;
      exp_q.sbe.rs1 = '0;
      exp_q.sbe.rs2 = '0;
      if (ok) begin
         exp_q.sbe.rs1 = 6'(m_map[rs1[4:0]]);
         exp_q.sbe.rs2 = 6'(m_map[rs2[4:0]]);
         if (ard != 0) exp_q.sbe.rd = 6'(p);
      end
      rel = (we && wa[5:0] != 0) ? m_prev[wa[5:0]] : 0;
      if (ok && ard != 0) begin
         m_prev[p] = m_map[ard];
         m_map[ard] = p;
         m_free.delete(p);
         inflight.push_back(p);
      end
      if (rel != 0) m_free[rel] = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      #1;
      vectors++;
      if (issue_q !== '0) begin
         miscompares++;
         $display("FAIL reset_issue_q: got %h want 0", issue_q);
      end
      apply_reset();
      drive_cycle(1, 1, 0, 7, 31, 0, 0);
      vectors++;
      if (issue_q.valid !== 1'b1 || issue_q.sbe.rd !== 6'd0 || issue_q.sbe.rs1 !== 6'd7 || issue_q.sbe.rs2 !== 6'd31) begin
         miscompares++;
         $display("FAIL reset_identity_map: got v=%b rd=%0d rs1=%0d rs2=%0d want v=1 rd=0 rs1=7 rs2=31",
                  issue_q.valid, issue_q.sbe.rd, issue_q.sbe.rs1, issue_q.sbe.rs2);
      end
   endtask

   task automatic test_directed_rename();
      apply_reset();
      drive_cycle(1, 1, 9, 0, 0, 0, 0);
      vectors++;
      if (issue_q.valid !== 1'b1 || issue_q.sbe.rd !== 6'd32) begin
         miscompares++;
         $display("FAIL li_ar9: got v=%b rd=%0d want v=1 rd=32", issue_q.valid, issue_q.sbe.rd);
      end
      drive_cycle(1, 1, 3, 4, 5, 1, 32);
      vectors++;
      if (issue_q.sbe.rd !== 6'd33 || issue_q.sbe.rs1 !== 6'd4 || issue_q.sbe.rs2 !== 6'd5) begin
         miscompares++;
         $display("FAIL add_ar3: got rd=%0d rs1=%0d rs2=%0d want rd=33 rs1=4 rs2=5",
                  issue_q.sbe.rd, issue_q.sbe.rs1, issue_q.sbe.rs2);
      end
      drive_cycle(1, 1, 5, 0, 0, 1, 33);
      vectors++;
      if (issue_q.valid !== 1'b1 || issue_q.sbe.rd !== 6'd9) begin
         miscompares++;
         $display("FAIL li_ar5_reuse: got v=%b rd=%0d want v=1 rd=9", issue_q.valid, issue_q.sbe.rd);
      end
      drive_cycle(1, 1, 8, 9, 0, 0, 0);
      vectors++;
      if (issue_q.sbe.rd !== 6'd3 || issue_q.sbe.rs1 !== 6'd32 || issue_q.sbe.rs2 !== 6'd0) begin
         miscompares++;
         $display("FAIL sub_ar8: got rd=%0d rs1=%0d rs2=%0d want rd=3 rs1=32 rs2=0",
                  issue_q.sbe.rd, issue_q.sbe.rs1, issue_q.sbe.rs2);
      end
   endtask

   task automatic test_not_accepted();
      drive_cycle(0, 1, 3, 8, 25, 0, 0);
      vectors++;
      if (issue_q !== exp_q || issue_q.valid !== 1'b0) begin
         miscompares++;
         $display("FAIL ready_low: got %h want %h", issue_q, exp_q);
      end
      drive_cycle(1, 0, 3, 8, 25, 0, 0);
      vectors++;
      if (issue_q !== exp_q || issue_q.valid !== 1'b0) begin
         miscompares++;
         $display("FAIL valid_low: got %h want %h", issue_q, exp_q);
      end
      drive_cycle(1, 1, 10, 8, 3, 0, 0);
      vectors++;
      if (issue_q.sbe.rd !== 6'd34 || issue_q.sbe.rs1 !== 6'd3 || issue_q.sbe.rs2 !== 6'd33) begin
         miscompares++;
         $display("FAIL after_bubble: got rd=%0d rs1=%0d rs2=%0d want rd=34 rs1=3 rs2=33",
                  issue_q.sbe.rd, issue_q.sbe.rs1, issue_q.sbe.rs2);
      end
   endtask

   task automatic test_rd_zero();
      drive_cycle(1, 1, 0, 9, 0, 0, 0);
      vectors++;
      if (issue_q.valid !== 1'b1 || issue_q.sbe.rd !== 6'd0 || issue_q.sbe.rs1 !== 6'd32 || issue_q.sbe.rs2 !== 6'd0) begin
         miscompares++;
         $display("FAIL rd_zero: got v=%b rd=%0d rs1=%0d rs2=%0d want v=1 rd=0 rs1=32 rs2=0",
                  issue_q.valid, issue_q.sbe.rd, issue_q.sbe.rs1, issue_q.sbe.rs2);
      end
      drive_cycle(1, 0, 0, 0, 0, 1, 0);
      drive_cycle(1, 1, 1, 0, 0, 0, 0);
      vectors++;
      if (issue_q.sbe.rd !== 6'd35) begin
         miscompares++;
         $display("FAIL rd_zero_no_alloc: got rd=%0d want rd=35", issue_q.sbe.rd);
      end
   endtask

   task automatic test_exhaust();
      apply_reset();
      for (int i = 0; i < 32; i++) begin
         drive_cycle(1, 1, (i % 31) + 1, 0, 0, 0, 0);
         vectors++;
         if (issue_q.valid !== 1'b1 || issue_q.sbe.rd !== 6'(32 + i)) begin
            miscompares++;
            $display("FAIL exhaust_alloc_%0d: got v=%b rd=%0d want v=1 rd=%0d", i, issue_q.valid, issue_q.sbe.rd, 32 + i);
         end
      end
      drive_cycle(1, 1, 4, 0, 0, 0, 0);
      vectors++;
      if (issue_q.valid !== 1'b0) begin
         miscompares++;
         $display("FAIL exhaust_drop: got v=%b want v=0", issue_q.valid);
      end
      drive_cycle(1, 0, 0, 0, 0, 1, 32);
      drive_cycle(1, 1, 4, 0, 0, 0, 0);
      vectors++;
      if (issue_q.valid !== 1'b1 || issue_q.sbe.rd !== 6'd1) begin
         miscompares++;
         $display("FAIL exhaust_retry: got v=%b rd=%0d want v=1 rd=1", issue_q.valid, issue_q.sbe.rd);
      end
   endtask

   task automatic test_random();
      bit we;
      int wa;
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         we = 1'b0;
         wa = 0;
         if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
            we = 1'b1;
            wa = inflight.pop_front();
         end else if ($urandom_range(0, 9) == 0) begin
            we = 1'b1;
         end
         drive_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                     ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), we, wa);
         vectors++;
         if (issue_q !== exp_q) begin
            miscompares++;
            $display("FAIL random_%0d: got %h want %h", i, issue_q, exp_q);
         end
      end
   endtask

   task automatic test_reset_midop();
      for (int i = 0; i < 5; i++) drive_cycle(1, 1, i + 1, i, i, 0, 0);
      #2;
      rst_ni = 1'b0;
      #1;
      vectors++;
      if (issue_q !== '0) begin
         miscompares++;
         $display("FAIL midop_async_clear: got %h want 0", issue_q);
      end
      apply_reset();
      drive_cycle(1, 1, 9, 1, 2, 0, 0);
      vectors++;
      if (issue_q.sbe.rd !== 6'd32 || issue_q.sbe.rs1 !== 6'd1 || issue_q.sbe.rs2 !== 6'd2) begin
         miscompares++;
         $display("FAIL midop_restore: got rd=%0d rs1=%0d rs2=%0d want rd=32 rs1=1 rs2=2",
                  issue_q.sbe.rd, issue_q.sbe.rs1, issue_q.sbe.rs2);
      end
   endtask

   initial begin
      model_reset();
      #2;
      test_reset();
      test_directed_rename();
      test_not_accepted();
      test_rd_zero();
      test_exhaust();
      test_random();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/renaming_map.md
RENAMING_MAP -- requirements
Module: renaming_map

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ARCH_REG_WIDTH, 5, architectural register index width (32 arch regs).
- PHYS_REG_WIDTH, 6, physical register index width (64 phys regs).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset.
- fetch_entry_ready_i, in, 1, issue_n is offered this cycle.
- issue_n, in, issue_struct_t (ariane_pkg), incoming instruction: valid, sbe.rd, sbe.rs1, sbe.rs2 (arch indices in low ARCH_REG_WIDTH bits).
- issue_q, out, issue_struct_t, registered renamed instruction: rd/rs1/rs2 are phys indices in the low PHYS_REG_WIDTH bits.
- waddr_i, in, PHYS_REG_WIDTH, phys rd of the committing instruction.
- we_gp_i, in, 1, commit strobe for waddr_i.

REQ-003 One clock; reset is asynchronous and active-low (rst_ni), all state on posedge clk_i.

Function
REQ-004 State:
- Map table: 32 x PHYS_REG_WIDTH.
- Free bitvector: 64 bits.
- Previous-mapping table: 64 x PHYS_REG_WIDTH, indexed by phys reg; holds the phys reg that the arch rd mapped to before that phys reg was allocated.

REQ-005 An instruction is accepted when fetch_entry_ready_i && issue_n.valid are both high at a posedge.

REQ-006 Accepted instruction: issue_q.sbe.rs1/rs2 shall equal map[rs1]/map[rs2], read before this instruction's own rd update (ADD ar5,ar5,ar3 reads old ar5).

REQ-007 Accepted instruction with rd != 0:
- Allocate the lowest-numbered free phys reg P.
- Set prev[P] = map[rd], map[rd] = P, clear free[P].
- issue_q.sbe.rd = P.

REQ-008 rd == 0: no allocation, no table update, issue_q.sbe.rd = 0; ar0 always maps to pr0 and pr0 is never free.

REQ-009 Non-register fields of issue_n are copied unchanged into issue_q. Upper bits of rd/rs1/rs2 above PHYS_REG_WIDTH are zero.

REQ-010 Latency: exactly one cycle; issue_q is updated at the same posedge that accepts.

REQ-011 When not accepted (ready low or valid low):
- issue_q.valid = 0; rd/rs1/rs2 = 0; other fields copied.
- No map, free-list or prev change.

REQ-012 Commit: we_gp_i high with waddr_i != 0 at a posedge sets free[prev[waddr_i]] (unless that value is 0). The new phys reg stays mapped.

REQ-013 we_gp_i high with waddr_i == 0 shall have no effect.

REQ-014 A reg freed at edge N is allocatable from edge N+1, not in the same edge. Commit and allocation in the same cycle both take effect.

REQ-015 Free list empty and an rd != 0 instruction offered:
- issue_q.valid = 0; no state change; instruction dropped.
- Upstream guarantees this does not occur.

REQ-016 Commits are in program order; there is no flush/rollback port.

Reset
REQ-017 On rst_ni low, asynchronously:
- map[i] = i for i = 0..31.
- free = 1 for pr32..pr63, 0 for pr0..pr31.
- prev = 0.
- issue_q all zero (valid = 0).

REQ-018 Reset mid-operation discards all in-flight mappings and restores REQ-017 state.

Verification
REQ-019 Reset, then LI ar9 accepted -> next cycle issue_q.valid = 1, rd = 32.

REQ-020 Continue: ADD ar3,ar4,ar5 with commit waddr = 32 -> rd = 33, rs1 = 4, rs2 = 5; pr9 freed.

REQ-021 Continue: LI ar5 with commit waddr = 33 -> rd = 9 (lowest free), pr3 freed. Then SUB ar8,ar9,ar0 -> rd = 3, rs1 = 32, rs2 = 0.

REQ-022 fetch_entry_ready_i = 0 or issue_n.valid = 0 (e.g. MUL ar3,ar8,ar25 invalid) -> issue_q.valid = 0; the following valid instruction still sees unchanged mappings.

REQ-023 ADD ar0,ar9,ar0 -> rd = 0, rs2 = 0, no free entry consumed. we_gp_i with waddr = 0 -> no state change.

REQ-024 Issue 32 rd != 0 instructions without commits -> pr32..pr63 allocated in ascending order. A 33rd -> issue_q.valid = 0. One commit, then retry -> allocates the freed reg.
